// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB-first, optional parity, one stop bit.
// Bit timing comes from an internal baud counter running on sys_clk.
module uart_tx #(
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned CLK_frq     = 100000000,
  parameter logic [1:0]  VERIFY_MODE = 2'b00
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       uart_tx_en,
  input  logic [7:0] uart_tx_data,
  output logic       uart_txd,
  output logic       uart_tx_busy,
  output logic       uart_tx_done
);

  localparam int unsigned Div  = CLK_frq / BAUD;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);
  // Mode 2'b01 is odd and 2'b11 is even; 2'b00 and 2'b10 send no parity bit.
  localparam bit ParityEn  = VERIFY_MODE[0];
  localparam bit ParityOdd = !VERIFY_MODE[1];

  typedef enum logic [2:0] {StIdle, StStart, StData, StVeri, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;
  logic            tick;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        txd_d = 1'b1;
        if (uart_tx_en) begin
          shift_d = uart_tx_data;
          par_d   = ParityOdd ? ~^uart_tx_data : ^uart_tx_data;
          state_d = StStart;
          txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = StData;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ParityEn ? StVeri : StStop;
            txd_d   = ParityEn ? par_q : 1'b1;
          end else begin
            // Look ahead one bit so the registered line changes exactly on the boundary.
            txd_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StVeri: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = StStop;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = StIdle;
          txd_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = (state_q != StIdle);
  assign uart_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no/odd/even parity) with DIV=10, cycle-exact line checks
// and a mid-bit line decoder that pops expected bytes from per-instance scoreboards.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [2:0] en;
  logic [7:0] dat [3];
  logic [2:0] txd, busy, done;
  logic [2:0] abort;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] sb2[$];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx #(.BAUD(100000), .CLK_frq(1000000), .VERIFY_MODE(2'b00)) u_none (
    .sys_clk(clk), .rst(rst), .uart_tx_en(en[0]), .uart_tx_data(dat[0]),
    .uart_txd(txd[0]), .uart_tx_busy(busy[0]), .uart_tx_done(done[0])
  );
  uart_tx #(.BAUD(100000), .CLK_frq(1000000), .VERIFY_MODE(2'b01)) u_odd (
    .sys_clk(clk), .rst(rst), .uart_tx_en(en[1]), .uart_tx_data(dat[1]),
    .uart_txd(txd[1]), .uart_tx_busy(busy[1]), .uart_tx_done(done[1])
  );
  uart_tx #(.BAUD(100000), .CLK_frq(1000000), .VERIFY_MODE(2'b11)) u_even (
    .sys_clk(clk), .rst(rst), .uart_tx_en(en[2]), .uart_tx_data(dat[2]),
    .uart_txd(txd[2]), .uart_tx_busy(busy[2]), .uart_tx_done(done[2])
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_par(input int m, input logic [7:0] d);
    if (m == 1) return ~^d;
    if (m == 2) return ^d;
    return 1'b0;
  endfunction

  task automatic push(input int m, input logic [7:0] d);
    case (m)
      0: sb0.push_back(d);
      1: sb1.push_back(d);
      default: sb2.push_back(d);
    endcase
  endtask

  task automatic send(input int m, input logic [7:0] d, input bit expect_frame);
    en[m]  = 1'b1;
    dat[m] = d;
    if (expect_frame) push(m, d);
    tick();
    en[m] = 1'b0;
  endtask

  // Called in the cycle after acceptance; checks every line cycle and the done cycle.
  task automatic check_frame(input int m, input logic [7:0] d, input bit scramble,
                             input bit nxt_en, input logic [7:0] nxt_d);
    logic [10:0] f;
    int n;
    n = (m == 0) ? 10 : 11;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (m != 0) f[9] = exp_par(m, d);
    for (int i = 0; i < n * 10; i++) begin
      chk($sformatf("txd m%0d d%0h c%0d", m, d, i + 1), {7'd0, txd[m]}, {7'd0, f[i / 10]});
      chk($sformatf("busy m%0d c%0d", m, i + 1), {7'd0, busy[m]}, 8'd1);
      chk($sformatf("done m%0d c%0d", m, i + 1), {7'd0, done[m]}, 8'd0);
      if (scramble) begin
        dat[m] = 8'($urandom);
        en[m]  = (i == 39);
      end
      tick();
    end
    en[m] = 1'b0;
    chk($sformatf("done_end m%0d", m), {7'd0, done[m]}, 8'd1);
    chk($sformatf("busy_end m%0d", m), {7'd0, busy[m]}, 8'd0);
    chk($sformatf("txd_end m%0d", m), {7'd0, txd[m]}, 8'd1);
    if (nxt_en) send(m, nxt_d, 1'b1);
  endtask

  task automatic samp(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  // Receive-side model: detects the falling start edge and samples each bit at mid-period.
  task automatic decode(input int m);
    logic       prev, st, p, s, have;
    logic [7:0] b, e;
    prev = 1'b1;
    forever begin
      samp(1);
      if (prev && !txd[m]) begin
        samp(4);
        st = txd[m];
        for (int i = 0; i < 8; i++) begin
          samp(10);
          b[i] = txd[m];
        end
        p = 1'b0;
        if (m != 0) begin
          samp(10);
          p = txd[m];
        end
        samp(10);
        s = txd[m];
        if (abort[m]) begin
          abort[m] = 1'b0;
        end else begin
          case (m)
            0: have = (sb0.size() > 0);
            1: have = (sb1.size() > 0);
            default: have = (sb2.size() > 0);
          endcase
          chk($sformatf("rx_pending m%0d", m), {7'd0, have}, 8'd1);
          e = 8'h00;
          if (have) begin
            case (m)
              0: e = sb0.pop_front();
              1: e = sb1.pop_front();
              default: e = sb2.pop_front();
            endcase
          end
          chk($sformatf("rx_start m%0d", m), {7'd0, st}, 8'd0);
          chk($sformatf("rx_byte m%0d", m), b, e);
          if (m != 0) chk($sformatf("rx_par m%0d", m), {7'd0, p}, {7'd0, exp_par(m, e)});
          chk($sformatf("rx_stop m%0d", m), {7'd0, s}, 8'd1);
        end
        prev = s;
      end else begin
        prev = txd[m];
      end
    end
  endtask

  initial decode(0);
  initial decode(1);
  initial decode(2);

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    en     = '0;
    abort  = '0;
    for (int i = 0; i < 3; i++) dat[i] = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst_txd m%0d", m), {7'd0, txd[m]}, 8'd1);
      chk($sformatf("rst_busy m%0d", m), {7'd0, busy[m]}, 8'd0);
      chk($sformatf("rst_done m%0d", m), {7'd0, done[m]}, 8'd0);
    end
    tick();

    send(0, 8'hA5, 1'b1);
    check_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00);

    send(1, 8'h07, 1'b1);
    check_frame(1, 8'h07, 1'b0, 1'b0, 8'h00);
    send(1, 8'h00, 1'b1);
    check_frame(1, 8'h00, 1'b0, 1'b0, 8'h00);

    send(2, 8'h07, 1'b1);
    check_frame(2, 8'h07, 1'b0, 1'b0, 8'h00);
    send(2, 8'hFF, 1'b1);
    check_frame(2, 8'hFF, 1'b0, 1'b0, 8'h00);

    // Request while busy plus a churning data bus must not disturb the frame.
    send(0, 8'h3C, 1'b1);
    check_frame(0, 8'h3C, 1'b1, 1'b0, 8'h00);
    repeat (3) tick();

    // Back-to-back: the second request is raised in the done cycle.
    send(0, 8'h55, 1'b1);
    check_frame(0, 8'h55, 1'b0, 1'b1, 8'hAA);
    check_frame(0, 8'hAA, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();

    // Abort at cycle 45 of a frame.
    send(0, 8'hC3, 1'b0);
    for (int i = 0; i < 44; i++) tick();
    abort[0] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("abort_txd c%0d", 46 + i), {7'd0, txd[0]}, 8'd1);
      chk($sformatf("abort_busy c%0d", 46 + i), {7'd0, busy[0]}, 8'd0);
      chk($sformatf("abort_done c%0d", 46 + i), {7'd0, done[0]}, 8'd0);
      tick();
    end
    repeat (40) tick();
    send(0, 8'h81, 1'b1);
    check_frame(0, 8'h81, 1'b0, 1'b0, 8'h00);

    repeat (20) tick();
    chk("sb0_drained", 8'(sb0.size()), 8'd0);
    chk("sb1_drained", 8'(sb1.size()), 8'd0);
    chk("sb2_drained", 8'(sb2.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
